// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - load-use / branch / data-memory-wait hazard controller for the 5-stage core
// Optional feature macro: HAZARD_PERF_EN (stall/flush performance counters)
module hazard_detection_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int PERF_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic                  idex_MemRead,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  hz_ctrl,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  IFID_flush,
    output logic                  pipe_hold,
    output logic                  mem_err,
    output logic [PERF_W-1:0]     stall_cycles,
    output logic [PERF_W-1:0]     flush_count
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LU_RELEASE = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_tmo_cnt;
    logic [7:0] w_tmo_cnt_next;
    logic       r_mem_err;
    logic       w_set_err;

    logic w_lu_hit;
    logic w_mem_busy;
    logic w_eval;
    logic w_busy_mask;
    logic w_lu_mask;

    logic w_hz_ctrl;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_pipe_hold;

    assign w_lu_hit = idex_MemRead && (idex_rd != '0) &&
                      ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));
    assign w_mem_busy = mem_req && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_tmo_cnt <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_tmo_cnt <= w_tmo_cnt_next;
            if (w_set_err) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_hz_ctrl      = 1'b0;
        w_pc_write     = 1'b1;
        w_ifid_write   = 1'b1;
        w_ifid_flush   = 1'b0;
        w_pipe_hold    = 1'b0;
        w_next_state   = ST_RUN;
        w_tmo_cnt_next = r_tmo_cnt;
        w_set_err      = 1'b0;
        w_eval         = 1'b0;
        w_busy_mask    = 1'b0;
        w_lu_mask      = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_eval = 1'b1;
            end
            ST_LU_RELEASE: begin
                w_eval    = 1'b1;
                w_lu_mask = 1'b1;
            end
            ST_MEM_WAIT: begin
                // The release cycle (ready or timeout) lets a held branch / load-use act immediately
                if (mem_ready) begin
                    w_eval         = 1'b1;
                    w_busy_mask    = 1'b1;
                    w_tmo_cnt_next = 8'd0;
                end else if (r_tmo_cnt >= TMO_LAST) begin
                    w_eval         = 1'b1;
                    w_busy_mask    = 1'b1;
                    w_set_err      = 1'b1;
                    w_tmo_cnt_next = 8'd0;
                end else begin
                    w_pc_write     = 1'b0;
                    w_ifid_write   = 1'b0;
                    w_pipe_hold    = 1'b1;
                    w_tmo_cnt_next = r_tmo_cnt + 8'd1;
                    w_next_state   = ST_MEM_WAIT;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase

        if (w_eval) begin
            if (w_mem_busy && !w_busy_mask) begin
                w_pc_write     = 1'b0;
                w_ifid_write   = 1'b0;
                w_pipe_hold    = 1'b1;
                w_tmo_cnt_next = 8'd1;
                w_next_state   = ST_MEM_WAIT;
            end else if (branch_taken) begin
                w_ifid_flush = 1'b1;
                w_hz_ctrl    = 1'b1;
                w_pc_write   = 1'b1;
                w_next_state = ST_RUN;
            end else if (w_lu_hit && !w_lu_mask) begin
                w_hz_ctrl    = 1'b1;
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                w_next_state = ST_LU_RELEASE;
            end
        end

        // Outputs fall to pass-through the moment reset is asserted, independent of the clock
        if (!rst_n) begin
            w_hz_ctrl    = 1'b0;
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = 1'b0;
            w_pipe_hold  = 1'b0;
        end
    end

    assign hz_ctrl    = w_hz_ctrl;
    assign PCWrite    = w_pc_write;
    assign IFIDWrite  = w_ifid_write;
    assign IFID_flush = w_ifid_flush;
    assign pipe_hold  = w_pipe_hold;
    assign mem_err    = r_mem_err;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!w_pc_write && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + PERF_W'(1);
            end
            if (w_ifid_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + PERF_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - randomized + directed self-checking bench for hazard_detection_unit
module tb_hazard_detection_unit;

    localparam int RW  = 5;
    localparam int TMO = 15;
    localparam int PW  = 16;
    localparam int PERF_MAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] id_rs1, id_rs2, idex_rd;
    logic          id_uses_rs2, idex_MemRead, branch_taken, mem_req, mem_ready;
    logic          hz_ctrl, PCWrite, IFIDWrite, IFID_flush, pipe_hold, mem_err;
    logic [PW-1:0] stall_cycles, flush_count;
    logic [5:0]    out_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: abstract "what is the pipe doing" view
    bit m_waiting;
    int m_wait_len;
    bit m_after_lu;
    bit m_err;
    int m_stall;
    int m_flush;
    bit n_waiting, n_after_lu, n_err;
    int n_wait_len;
    bit e_hz, e_pcw, e_ifw, e_fl, e_hold;
    logic [5:0] e_vec;

    hazard_detection_unit #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TMO), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .idex_MemRead(idex_MemRead), .idex_rd(idex_rd),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .hz_ctrl(hz_ctrl), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFID_flush(IFID_flush), .pipe_hold(pipe_hold), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign out_vec = {hz_ctrl, PCWrite, IFIDWrite, IFID_flush, pipe_hold, mem_err};

    task automatic model_reset();
        m_waiting = 0; m_wait_len = 0; m_after_lu = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_comb();
        bit lu, busy, act, ign_busy, ign_lu;
        lu = idex_MemRead && (idex_rd != 0) &&
             ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));
        busy = mem_req && !mem_ready;
        {e_hz, e_pcw, e_ifw, e_fl, e_hold} = 5'b01100;
        n_waiting = 0; n_wait_len = 0; n_after_lu = 0; n_err = m_err;
        act = 1; ign_busy = 0; ign_lu = m_after_lu;
        if (m_waiting) begin
            if (mem_ready) begin
                ign_busy = 1;
            end else if (m_wait_len >= TMO) begin
                ign_busy = 1;
                n_err = 1;
            end else begin
                act = 0;
                {e_pcw, e_ifw, e_hold} = 3'b001;
                n_waiting = 1;
                n_wait_len = m_wait_len + 1;
            end
        end
        if (act) begin
            if (busy && !ign_busy) begin
                {e_pcw, e_ifw, e_hold} = 3'b001;
                n_waiting = 1;
                n_wait_len = 1;
            end else if (branch_taken) begin
                e_fl = 1; e_hz = 1;
            end else if (lu && !ign_lu) begin
                e_hz = 1; e_pcw = 0; e_ifw = 0;
                n_after_lu = 1;
            end
        end
        e_vec = {e_hz, e_pcw, e_ifw, e_fl, e_hold, m_err};
    endtask

    task automatic model_commit();
        if (!e_pcw && m_stall < PERF_MAX) m_stall++;
        if (e_fl && m_flush < PERF_MAX) m_flush++;
        m_waiting = n_waiting; m_wait_len = n_wait_len; m_after_lu = n_after_lu; m_err = n_err;
    endtask

    function automatic int exp_stall();
`ifdef HAZARD_PERF_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_flush();
`ifdef HAZARD_PERF_EN
        return m_flush;
`else
        return 0;
`endif
    endfunction

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_in(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2, input bit u2,
                          input bit mr, input logic [RW-1:0] rd, input bit br,
                          input bit req, input bit rdy);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; idex_MemRead = mr; idex_rd = rd;
        branch_taken = br; mem_req = req; mem_ready = rdy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        #1;
        if (out_vec !== 6'b011000) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", out_vec, 6'b011000);
        end
        checks++;
        if (stall_cycles !== '0 || flush_count !== '0) begin
            errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", stall_cycles, flush_count);
        end
        checks++;
        @(negedge clk);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        model_reset();
        advance();
    endtask

    task automatic test_load_use();
        logic [5:0] want [3];
        want[0] = 6'b100000; want[1] = 6'b011000; want[2] = 6'b100000;
        set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); model_comb();
            if (out_vec !== want[i]) begin
                errors++; $display("FAIL load_use cyc%0d: got %b want %b", i, out_vec, want[i]);
            end
            checks++;
            advance();
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); model_comb(); advance();
    endtask

    task automatic test_no_hazard();
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); model_comb();
        if (out_vec !== 6'b011000) begin
            errors++; $display("FAIL no_hazard_x0: got %b want %b", out_vec, 6'b011000);
        end
        checks++;
        advance();
        set_in(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk); model_comb();
        if (out_vec !== 6'b011000) begin
            errors++; $display("FAIL no_hazard_rs2_unused: got %b want %b", out_vec, 6'b011000);
        end
        checks++;
        advance();
    endtask

    task automatic test_branch();
        set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        @(negedge clk); model_comb();
        if (out_vec !== 6'b111100) begin
            errors++; $display("FAIL branch_over_lu: got %b want %b", out_vec, 6'b111100);
        end
        checks++;
        advance();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); model_comb();
`ifdef HAZARD_PERF_EN
        if (flush_count !== PW'(1)) begin
            errors++; $display("FAIL branch_flush_count: got %0d want 1", flush_count);
        end
`else
        if (flush_count !== '0) begin
            errors++; $display("FAIL branch_flush_count: got %0d want 0", flush_count);
        end
`endif
        checks++;
        advance();
    endtask

    task automatic test_mem_wait();
        int holds;
        int stall0;
        holds = 0;
        stall0 = exp_stall();
        for (int i = 0; i < 5; i++) begin
            set_in(5'd3, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, (i == 4));
            @(negedge clk); model_comb();
            if (out_vec !== ((i == 4) ? 6'b011000 : 6'b000010)) begin
                errors++; $display("FAIL mem_wait cyc%0d: got %b", i, out_vec);
            end
            checks++;
            if (pipe_hold) holds++;
            advance();
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); model_comb();
        if (holds != 4) begin
            errors++; $display("FAIL mem_wait_len: got %0d want 4", holds);
        end
        checks++;
`ifdef HAZARD_PERF_EN
        if (int'(stall_cycles) != stall0 + 4) begin
            errors++; $display("FAIL mem_wait_stalls: got %0d want %0d", stall_cycles, stall0 + 4);
        end
        checks++;
`endif
        advance();
    endtask

    task automatic test_timeout();
        int holds;
        bit released;
        holds = 0;
        released = 0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40 && !released; i++) begin
            @(negedge clk); model_comb();
            if (out_vec !== e_vec) begin
                errors++; $display("FAIL timeout cyc%0d: got %b want %b", i, out_vec, e_vec);
            end
            checks++;
            if (pipe_hold) holds++;
            else released = 1;
            advance();
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        if (!released || holds != TMO) begin
            errors++; $display("FAIL timeout_len: got %0d want %0d (released=%0d)", holds, TMO, released);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); model_comb();
            if (mem_err !== 1'b1) begin
                errors++; $display("FAIL mem_err_sticky cyc%0d: got %b want 1", i, mem_err);
            end
            checks++;
            advance();
        end
    endtask

    task automatic test_reset_mid_wait();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); model_comb(); advance();
        end
        #2;
        rst_n = 1'b0;
        #1;
        if ({pipe_hold, PCWrite, IFIDWrite, mem_err} !== 4'b0110) begin
            errors++; $display("FAIL reset_mid_wait: got %b want 0110", {pipe_hold, PCWrite, IFIDWrite, mem_err});
        end
        checks++;
        @(negedge clk);
        model_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        model_comb();
        if (out_vec !== 6'b011000) begin
            errors++; $display("FAIL post_reset_run: got %b want 011000", out_vec);
        end
        checks++;
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            set_in(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 2) != 0), RW'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 3) != 0));
            if (i >= 700 && i < 760) mem_ready = 1'b0;
            @(negedge clk); model_comb();
            if (out_vec !== e_vec) begin
                errors++; $display("FAIL random cyc%0d: got %b want %b", i, out_vec, e_vec);
            end
            checks++;
            if (int'(stall_cycles) != exp_stall() || int'(flush_count) != exp_flush()) begin
                errors++; $display("FAIL random_perf cyc%0d: got %0d/%0d want %0d/%0d",
                                   i, stall_cycles, flush_count, exp_stall(), exp_flush());
            end
            checks++;
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
